seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Display controller for a 4-digit multiplexed 7-segment panel. It accepts a 14-bit binary value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 engine. It then time-multiplexes the digits over one shared active-low segment bus. It sits between datapath logic producing counts/results and the board's common-anode display, and reuses the team's standard digit-to-segment encoding.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit is held enabled; legal range ≥ 2.
- BLANK_LEAD, default 1: 1 = blank leading zeros in digits 3..1; 0 = show all digits.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  1  single-cycle request to display `value`; honoured only when busy=0.
- value  in  14  unsigned binary value to display; legal display range 0..9999.
- busy  out  1  conversion in progress; load ignored while high.
- an  out  4  digit enables, active-low, one-hot-zero; an[0]=units, an[3]=thousands.
- seg  out  7  segments, active-low, {a,b,c,d,e,f,g} with seg[6]=a, seg[0]=g.

## Operation
- Segment codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111, dash=1111110.
- Converter FSM: IDLE → CONV → COMMIT → IDLE.
  - IDLE: load=1 latches value into a shift register, clears the 16-bit BCD accumulator, sets ovf_pend = (value > 9999), and goes to CONV.
  - CONV: runs exactly 14 iterations, 1 per cycle. Each iteration first adds 3 to every BCD nibble ≥5, then shifts the {bcd, bin} pair left by 1, MSB first.
  - COMMIT: copies the accumulator into the 4 display digit registers and ovf_pend into the ovf register. Returns to IDLE.
- Display registers are double-buffered; they change only in COMMIT. Scanning never pauses or restarts on a load.
- load while busy=1 is dropped, not queued. load in the same cycle busy falls is also dropped.
- Scanner:
  - A prescaler counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and digit index idx advances 0→1→2→3→0.
  - an = ~(4'b0001 << idx).
- Per-digit seg selection, in priority order:
  1. ovf=1: dash on all digits.
  2. BLANK_LEAD=1 and idx>0 and all digits at positions idx..3 are zero: blank.
  3. Otherwise: code of digit[idx].
  - The units digit is never blanked.
- Values 10000..16383 display as "----".

## Timing
- Reset, with rst_n=0 sampled at an edge:
  - FSM=IDLE, busy=0, prescaler=0, idx=0.
  - Display digits=0, ovf=0.
  - an=4'b1110, seg=7'b0000001.
  - Reset mid-conversion aborts it; the display returns to 0.
- busy and an/seg are registered outputs.
- Load latency: load sampled at edge E0.
  - busy=1 from E0 through E15: 14 CONV edges plus 1 COMMIT edge. busy=0 after E15.
  - Display registers update at E15.
  - seg reflects the new value at E16.
- Throughput: at most 1 accepted load per 16 cycles.
- Scan: each digit is enabled for exactly REFRESH_DIV cycles. idx, an and seg change on the same edge; there is never a cycle with two digits enabled. Full frame = 4·REFRESH_DIV cycles.
- A commit mid-digit alters seg for the currently enabled digit 1 cycle later, without disturbing an or the prescaler.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with load=1 → busy=0, an=1110, seg=0000001. After release with REFRESH_DIV=4, an steps 1110→1101→1011→0111 every 4 cycles. With BLANK_LEAD=1, seg=1111111 on digits 1..3.
- Conversion, BLANK_LEAD=0: load value=1234 → busy high exactly 15 cycles. Scan then shows an=1110 seg=1001100 (4), 1101/0000110 (3), 1011/0010010 (2), 0111/1001111 (1).
- Boundaries: value=9999 → all digits 0000100. value=10000 and value=16383 → all digits 1111110. value=0 with BLANK_LEAD=1 → units 0000001, others 1111111. value=105 with BLANK_LEAD=1 → digits 3 blank, 2=1001111, 1=0000001 (interior zero shown), 0=0100100.
- Load while busy: load 42, then load 77 at cycles +1, +8 and +15 → display shows 42. A later load 77 with busy=0 → display shows 77.
- Reset mid-conversion: load 8888, assert rst_n=0 at cycle +7 → busy=0 next edge and display digits all 0. A subsequent load 5 converts normally.
- Mid-digit commit: REFRESH_DIV=20, commit lands at prescaler=10 on idx=2 → an unchanged, seg for digit 2 updates 1 cycle after commit, and idx advances on schedule.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment controller with binary-to-BCD converter
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LEAD  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [13:0] value,
   output logic        busy,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_ZERO  = 7'b0000001;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [3:0]    cnt;
   logic [13:0]   bin;
   logic [15:0]   bcd;
   logic [15:0]   bcd_adj;
   logic          ovf_pend;
   logic [15:0]   disp;
   logic          ovf;
   logic          do_load;
   logic          do_shift;
   logic          do_commit;
   logic          busy_n;

   logic [PW-1:0] presc;
   logic          wrap;
   logic [1:0]    idx;
   logic [1:0]    idx_n;
   logic [3:0]    digit_n;
   logic          lead_zero;
   logic [6:0]    seg_n;

   // team digit-to-segment encoding, active-low {a,b,c,d,e,f,g}
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b0000001;
         4'd1:    seg_code = 7'b1001111;
         4'd2:    seg_code = 7'b0010010;
         4'd3:    seg_code = 7'b0000110;
         4'd4:    seg_code = 7'b1001100;
         4'd5:    seg_code = 7'b0100100;
         4'd6:    seg_code = 7'b0100000;
         4'd7:    seg_code = 7'b0001111;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0000100;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

   // converter state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // converter next state: 14 shift iterations, then a single commit cycle
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (load) state_n = S_CONV;
         S_CONV:   if (cnt == 4'd13) state_n = S_COMMIT;
         S_COMMIT: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // converter control decode; loads outside IDLE (including COMMIT) are dropped
   always_comb begin
      do_load   = 1'b0;
      do_shift  = 1'b0;
      do_commit = 1'b0;
      case (state)
         S_IDLE:   do_load   = load;
         S_CONV:   do_shift  = 1'b1;
         S_COMMIT: do_commit = 1'b1;
         default:  ;
      endcase
      busy_n = (state_n != S_IDLE);
   end

   // registered busy flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 1'b0;
      end else begin
         busy <= busy_n;
      end
   end

   // add-3 correction on every BCD nibble that is 5 or more
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   // shift-add-3 datapath; a carry out of the thousands digit also flags overflow
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
      end else if (do_load) begin
         bin      <= value;
         bcd      <= '0;
         cnt      <= '0;
         ovf_pend <= (value > 14'd9999);
      end else if (do_shift) begin
         {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
         cnt        <= cnt + 4'd1;
         ovf_pend   <= ovf_pend | bcd_adj[15];
      end
   end

   // display buffer, only written on commit so scanning never sees partial results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp <= '0;
         ovf  <= 1'b0;
      end else if (do_commit) begin
         disp <= bcd;
         ovf  <= ovf_pend;
      end
   end

   assign wrap  = (presc == PRESC_LAST);
   assign idx_n = wrap ? idx + 2'd1 : idx;

   // segment pattern for the digit that will be enabled after this edge
   always_comb begin
      digit_n   = disp[3:0];
      lead_zero = 1'b0;
      case (idx_n)
         2'd0: digit_n = disp[3:0];
         2'd1: begin
            digit_n   = disp[7:4];
            lead_zero = (disp[15:4] == 12'd0);
         end
         2'd2: begin
            digit_n   = disp[11:8];
            lead_zero = (disp[15:8] == 8'd0);
         end
         2'd3: begin
            digit_n   = disp[15:12];
            lead_zero = (disp[15:12] == 4'd0);
         end
         default: ;
      endcase
      if (ovf) begin
         seg_n = SEG_DASH;
      end else if ((BLANK_LEAD != 0) && lead_zero) begin
         seg_n = SEG_BLANK;
      end else begin
         seg_n = seg_code(digit_n);
      end
   end

   // free-running scanner; idx, an and seg all move on the same edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= 2'd0;
         an    <= 4'b1110;
         seg   <= SEG_ZERO;
      end else begin
         presc <= wrap ? '0 : presc + PW'(1);
         idx   <= idx_n;
         an    <= ~(4'b0001 << idx_n);
         seg   <= seg_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   typedef logic [3:0][6:0] frame_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        load  = 1'b0;
   logic [13:0] value = '0;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  seg;

   int     n_checks = 0;
   int     n_err    = 0;
   frame_t exp_q[$];

   seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LEAD(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .value (value),
      .busy  (busy),
      .an    (an),
      .seg   (seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [6:0] code(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         default: return 7'b0000100;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(input int v, input int i);
      int p;
      p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
      if (v > 9999) return 7'b1111110;
      if (i > 0 && v < p) return 7'b1111111;
      return code((v / p) % 10);
   endfunction

   function automatic frame_t model_frame(input int v);
      frame_t f;
      for (int i = 0; i < 4; i++) f[i] = model_seg(v, i);
      return f;
   endfunction

   task automatic start_load(input int v);
      load  = 1'b1;
      value = 14'(v);
      tick();
      load  = 1'b0;
   endtask

   task automatic wait_busy_len(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk(tag, n, 15);
   endtask

   task automatic check_frame(input string tag);
      frame_t     e;
      frame_t     got;
      logic [3:0] seen;
      int         bad;
      int         n;
      if (exp_q.size() == 0) begin
         chk($sformatf("%s_queue", tag), 0, 1);
         return;
      end
      e = exp_q.pop_front();
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         n++;
         tick();
      end
      chk($sformatf("%s_busy_to", tag), (n >= 40), 0);
      tick();
      got  = '0;
      seen = '0;
      bad  = 0;
      for (int k = 0; k < FRAME; k++) begin
         case (an)
            4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
            4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
            4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
            4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
            default: bad++;
         endcase
         tick();
      end
      chk($sformatf("%s_an_ok", tag), {bad[27:0], seen}, 32'hf);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_d%0d", tag, i), got[i], e[i]);
      end
   endtask

   task automatic load_and_check(input int v, input string tag);
      exp_q.push_back(model_frame(v));
      start_load(v);
      wait_busy_len($sformatf("%s_busy_len", tag));
      check_frame(tag);
   endtask

   initial begin
      logic [3:0] ea;
      logic [6:0] es;
      int         n;

      rst_n = 1'b0;
      load  = 1'b1;
      value = 14'd1234;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_an", an, 4'b1110);
      chk("rst_seg", seg, 7'b0000001);
      load  = 1'b0;
      rst_n = 1'b1;

      for (int k = 0; k < FRAME; k++) begin
         if (k > 0) tick();
         ea = ~(4'b0001 << (k / DIV));
         es = (k < DIV) ? 7'b0000001 : 7'b1111111;
         chk($sformatf("scan_an_%0d", k), an, ea);
         chk($sformatf("scan_seg_%0d", k), seg, es);
      end
      tick();

      load_and_check(1234, "v1234");
      load_and_check(9999, "v9999");
      load_and_check(10000, "v10000");
      load_and_check(16383, "v16383");
      load_and_check(0, "v0");
      load_and_check(105, "v105");

      exp_q.push_back(model_frame(42));
      start_load(42);
      for (int k = 1; k <= 15; k++) begin
         load  = (k == 1 || k == 8 || k == 15);
         value = 14'd77;
         tick();
      end
      load = 1'b0;
      check_frame("drop42");
      load_and_check(77, "v77");

      start_load(8888);
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_busy", busy, 0);
      exp_q.push_back(model_frame(0));
      check_frame("midrst");
      load_and_check(5, "v5");

      n = 0;
      while (an === 4'b1011 && n < 100) begin
         n++;
         tick();
      end
      while (an !== 4'b1011 && n < 100) begin
         n++;
         tick();
      end
      chk("md_sync_to", (n >= 100), 0);
      exp_q.push_back(model_frame(1357));
      repeat (2) tick();
      start_load(1357);
      repeat (15) tick();
      chk("md_busy", busy, 0);
      chk("md_an_commit", an, 4'b1011);
      chk("md_seg_commit", seg, 7'b1111111);
      tick();
      chk("md_an_after", an, 4'b1011);
      chk("md_seg_after", seg, model_seg(1357, 2));
      tick();
      chk("md_an_adv", an, 4'b0111);
      chk("md_seg_adv", seg, model_seg(1357, 3));
      check_frame("md");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
